// File: rtl/lp_alu_seq_if.sv
// Request/response bundle for lp_alu_seq: valid/ready request channel carrying
// op/a/b, valid/ready response channel carrying the result and status flags.
interface lp_alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  // Issue logic / writeback side
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/lp_alu_seq.sv
// Sequential low-power ALU. Each functional unit owns its operand registers and
// only the unit selected by the accepted op loads them, so idle units stay
// quiet. Shifts run one bit per cycle. One operation in flight at a time.
module lp_alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  lp_alu_seq_if.slave      bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAndn = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b110;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpSll  = 3'b101;
  localparam logic [2:0] OpSrl  = 3'b011;
  localparam logic [2:0] OpRor  = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  // Adder group
  logic [WIDTH-1:0] add_a_q, add_b_q;
  // Logic group
  logic [WIDTH-1:0] log_a_q, log_b_q;
  // Shifter group
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   sh_cnt_q;
  // Outputs
  logic [WIDTH-1:0] result_q;
  logic             flag_z_q, flag_c_q, flag_v_q, out_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic             in_is_add, in_is_log;
  logic [SHW-1:0]   in_shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c, exec_v;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  assign in_is_add = (bus.op == OpAdd) || (bus.op == OpSub);
  assign in_is_log = (bus.op == OpAndn) || (bus.op == OpAnd) || (bus.op == OpXor);
  assign in_shamt  = bus.b[SHW-1:0];

  // Execute-stage datapath, fed only from the isolation registers
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    sum      = '0;
    unique case (op_q)
      OpAdd: begin
        sum      = {1'b0, add_a_q} + {1'b0, add_b_q};
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
        exec_v   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                   (sum[WIDTH-1] != add_a_q[WIDTH-1]);
      end
      OpSub: begin
        sum      = {1'b0, add_a_q} + {1'b0, ~add_b_q} + {{WIDTH{1'b0}}, 1'b1};
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
        exec_v   = (add_a_q[WIDTH-1] != add_b_q[WIDTH-1]) &&
                   (sum[WIDTH-1] != add_a_q[WIDTH-1]);
      end
      OpAndn: exec_res = ~log_a_q & log_b_q;
      OpAnd:  exec_res = log_a_q & log_b_q;
      OpXor:  exec_res = log_a_q ^ log_b_q;
      // Zero-length shift: working register still holds a
      OpSll, OpSrl, OpRor: exec_res = sh_q;
      default: exec_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter
  always_comb begin
    sh_next = sh_q;
    sh_out  = 1'b0;
    unique case (op_q)
      OpSll: begin
        sh_next = {sh_q[WIDTH-2:0], 1'b0};
        sh_out  = sh_q[WIDTH-1];
      end
      OpSrl: begin
        sh_next = {1'b0, sh_q[WIDTH-1:1]};
        sh_out  = sh_q[0];
      end
      OpRor: sh_next = {sh_q[0], sh_q[WIDTH-1:1]};
      default: sh_next = sh_q;
    endcase
  end

  // Control FSM with registered result, flags, handshake and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      log_a_q     <= '0;
      log_b_q     <= '0;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q <= bus.op;
            if (in_is_add) begin
              add_a_q <= bus.a;
              add_b_q <= bus.b;
              state_q <= StExec;
            end else if (in_is_log) begin
              log_a_q <= bus.a;
              log_b_q <= bus.b;
              state_q <= StExec;
            end else begin
              sh_q     <= bus.a;
              sh_cnt_q <= in_shamt;
              state_q  <= (in_shamt == '0) ? StExec : StShift;
            end
          end
        end
        StExec: begin
          result_q    <= exec_res;
          flag_z_q    <= (exec_res == '0);
          flag_c_q    <= exec_c;
          flag_v_q    <= exec_v;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StShift: begin
          sh_q     <= sh_next;
          sh_cnt_q <= sh_cnt_q - SHW'(1);
          if (sh_cnt_q == SHW'(1)) begin
            result_q    <= sh_next;
            flag_z_q    <= (sh_next == '0);
            flag_c_q    <= sh_out;
            flag_v_q    <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is withheld while reset is held so nothing is issued into a resetting block
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;
  assign busy          = (state_q != StIdle);
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_lp_alu_seq.sv
// Directed bench for lp_alu_seq (WIDTH=8): a vector table for single
// operations plus hand-written backpressure and mid-shift reset sequences.
module tb_lp_alu_seq;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] op_count;

  lp_alu_seq_if #(.WIDTH(8)) bus ();

  lp_alu_seq #(.WIDTH(8), .SHW(3), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    int         lat;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs [NVec];

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one op, measure latency in cycles after acceptance, check, then consume
  task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic ec,
                        input logic ev, input logic ez, input int el);
    int n;
    @(negedge clk);
    check({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 3'b100;
    bus.a  = 8'hA5;
    bus.b  = 8'h5A;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, el);
    check({nm, "_result"}, {24'd0, bus.result}, {24'd0, er});
    check({nm, "_c"}, {31'd0, bus.flag_c}, {31'd0, ec});
    check({nm, "_v"}, {31'd0, bus.flag_v}, {31'd0, ev});
    check({nm, "_z"}, {31'd0, bus.flag_z}, {31'd0, ez});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    check({nm, "_op_count"}, {16'd0, op_count}, exp_cnt);
    check({nm, "_out_valid_clr"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 2};  // ADD carry
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 2};  // SUB equal
    vecs[2]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 2};  // SUB overflow
    vecs[3]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 2};  // ADD overflow
    vecs[4]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 2};  // SUB borrow
    vecs[5]  = '{3'b101, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4};  // SLL 3
    vecs[6]  = '{3'b011, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 2};  // SRL 1
    vecs[7]  = '{3'b111, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b0, 1'b0, 2};  // ROR 1
    vecs[8]  = '{3'b011, 8'h81, 8'h0A, 8'h20, 1'b0, 1'b0, 1'b0, 3};  // SRL, upper b ignored
    vecs[9]  = '{3'b101, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 2};  // SLL to zero
    vecs[10] = '{3'b101, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 2};  // SLL shamt=0
    vecs[11] = '{3'b010, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0, 2};  // ANDN
    vecs[12] = '{3'b110, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 2};  // AND
    vecs[13] = '{3'b100, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 2};  // XOR zero

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 3'b000;
    bus.a  = 8'h00;
    bus.b  = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_result", {24'd0, bus.result}, 32'd0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < NVec; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].lat);
    end

    // Logic ops must not have disturbed the adder or shifter operand registers
    check("iso_add_a", {24'd0, dut.add_a_q}, 32'h00);
    check("iso_add_b", {24'd0, dut.add_b_q}, 32'h01);
    check("iso_sh_q", {24'd0, dut.sh_q}, 32'h81);
    check("iso_sh_cnt", {29'd0, dut.sh_cnt_q}, 32'd0);

    // Backpressure: ADD 0x12+0x34 held in DONE for 5 cycles
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'b000;
    bus.a  = 8'h12;
    bus.b  = 8'h34;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, 2);
    for (int k = 0; k < 5; k++) begin
      // Pulse a request mid-hold; it must be ignored
      if (k == 2) begin
        bus.in_valid = 1'b1;
        bus.op = 3'b100;
        bus.a  = 8'hFF;
        bus.b  = 8'h00;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp_result_%0d", k), {24'd0, bus.result}, 32'h46);
      check($sformatf("bp_flags_%0d", k), {29'd0, bus.flag_c, bus.flag_v, bus.flag_z}, 32'd0);
      check($sformatf("bp_in_ready_%0d", k), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("bp_out_valid_%0d", k), {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    check("bp_busy_after", {31'd0, busy}, 32'd0);
    check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("bp_op_count", {16'd0, op_count}, exp_cnt);
    check("bp_ignored_req", {24'd0, dut.log_a_q}, 32'h3C);
    @(negedge clk);
    check("bp_no_extra_count", {16'd0, op_count}, exp_cnt);

    // Reset in the middle of SRL by 7: accepted in cycle 0, reset in cycle 3
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'b011;
    bus.a  = 8'h81;
    bus.b  = 8'h07;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rs_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_result", {24'd0, bus.result}, 32'd0);
    check("rs_flags", {29'd0, bus.flag_c, bus.flag_v, bus.flag_z}, 32'd0);
    check("rs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_op_count", {16'd0, op_count}, 32'd0);
    check("rs_sh_cnt", {29'd0, dut.sh_cnt_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    check("rs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_op("rs_add", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
